collatz_seq_engine: RTL and testbench

- Sequential, parametrised Collatz engine. It accepts a WIDTH-bit start value over a valid/ready handshake and iterates n -> n/2 (even) or 3n+1 (odd), one step per clock, until n reaches 1.
- It returns the step count and a status code over a second valid/ready handshake.
- It supersedes the fixed-width combinational collatz block. It sits behind the project I/O wrapper and is exercised by the cocotb bench.

---
 rtl/collatz_pkg.sv | 15 +
 rtl/collatz_seq_engine_if.sv | 38 +++
 rtl/collatz_step_unit.sv | 30 +++
 rtl/collatz_seq_engine.sv | 160 ++++++++++++++++
 tb/tb_collatz_seq_engine.sv | 318 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/collatz_pkg.sv
// Shared definitions for the Collatz sequence engine: FSM states and result codes.
package collatz_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam logic [1:0] ST_OK    = 2'b00;
    localparam logic [1:0] ST_ZERO  = 2'b01;
    localparam logic [1:0] ST_OVF   = 2'b10;
    localparam logic [1:0] ST_LIMIT = 2'b11;

endpackage

// File: rtl/collatz_seq_engine_if.sv
// Start/result handshake bundle of the Collatz engine.
// With COLLATZ_PEAK_EN defined the bundle also carries the running peak value.
interface collatz_seq_engine_if #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8
);
    logic             start_valid;
    logic             start_ready;
    logic [WIDTH-1:0] start_value;
    logic [WIDTH-1:0] cur_value;
    logic             busy;
    logic             done_valid;
    logic             done_ready;
    logic [CNT_W-1:0] steps;
    logic [1:0]       status;
`ifdef COLLATZ_PEAK_EN
    logic [WIDTH-1:0] peak;
`endif

    // Producer of start values and consumer of results.
    modport master (
        output start_valid, start_value, done_ready,
        input  start_ready, cur_value, busy, done_valid, steps, status
`ifdef COLLATZ_PEAK_EN
        , input peak
`endif
    );

    // The engine itself.
    modport slave (
        input  start_valid, start_value, done_ready,
        output start_ready, cur_value, busy, done_valid, steps, status
`ifdef COLLATZ_PEAK_EN
        , output peak
`endif
    );

endinterface

// File: rtl/collatz_step_unit.sv
// One combinational Collatz step: n/2 for even n, 3n+1 for odd n.
// The odd branch is computed two bits wider so an out-of-range result is flagged
// instead of silently truncated.
module collatz_step_unit #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] n,
    output logic [WIDTH-1:0] next_n,
    output logic             ovf,
    output logic             is_one,
    output logic             is_zero
);

    logic [WIDTH+1:0] triple_s;

    // Next value, overflow detection and terminal-value decode.
    always_comb begin
        triple_s = {2'b00, n} + {1'b0, n, 1'b0} + {{(WIDTH+1){1'b0}}, 1'b1};
        if (n[0]) begin
            next_n = triple_s[WIDTH-1:0];
            ovf    = (triple_s[WIDTH+1:WIDTH] != 2'b00);
        end else begin
            next_n = {1'b0, n[WIDTH-1:1]};
            ovf    = 1'b0;
        end
        is_one  = (n == {{(WIDTH-1){1'b0}}, 1'b1});
        is_zero = (n == {WIDTH{1'b0}});
    end

endmodule

// File: rtl/collatz_seq_engine.sv
// Sequential Collatz engine: accepts a start value, iterates one step per clock
// until the value reaches 1, then reports step count and status.
// Optional feature macro: COLLATZ_PEAK_EN (adds the peak output register).
module collatz_seq_engine
    import collatz_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8
) (
    input  logic clk,
    input  logic rst_n,
    collatz_seq_engine_if.slave bus
);

    localparam logic [CNT_W-1:0] STEP_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] STEP_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [1:0]       rst_sync_r;
    logic             rst_int_n_s;
    state_t           state_r;
    logic [WIDTH-1:0] cur_r;
    logic [CNT_W-1:0] steps_r;
    logic [1:0]       status_r;
    logic             busy_r;
    logic             done_valid_r;
    logic             start_ready_r;

    logic [WIDTH-1:0] next_s;
    logic             ovf_s;
    logic             is_one_s;
    logic             is_zero_s;
    logic             accept_s;
    logic             limit_s;
    logic             advance_s;

    collatz_step_unit #(.WIDTH(WIDTH)) u_step (
        .n       (cur_r),
        .next_n  (next_s),
        .ovf     (ovf_s),
        .is_one  (is_one_s),
        .is_zero (is_zero_s)
    );

    // Reset synchroniser: assertion is immediate, release is aligned to clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync_r <= 2'b00;
        end else begin
            rst_sync_r <= {rst_sync_r[0], 1'b1};
        end
    end

    assign rst_int_n_s = rst_sync_r[1];

    // Handshake and step-decision terms decoded from the registered state.
    always_comb begin
        accept_s  = (state_r == IDLE) && bus.start_valid && start_ready_r;
        limit_s   = (steps_r == STEP_MAX);
        advance_s = (state_r == RUN) && !is_zero_s && !is_one_s && !limit_s && !ovf_s;
    end

    // Main FSM: IDLE accepts, RUN iterates with prioritised exits, DONE waits for the consumer.
    always_ff @(posedge clk or negedge rst_int_n_s) begin
        if (!rst_int_n_s) begin
            state_r       <= IDLE;
            cur_r         <= {WIDTH{1'b0}};
            steps_r       <= {CNT_W{1'b0}};
            status_r      <= ST_OK;
            busy_r        <= 1'b0;
            done_valid_r  <= 1'b0;
            start_ready_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        state_r       <= RUN;
                        cur_r         <= bus.start_value;
                        steps_r       <= {CNT_W{1'b0}};
                        status_r      <= ST_OK;
                        busy_r        <= 1'b1;
                        start_ready_r <= 1'b0;
                    end else begin
                        start_ready_r <= 1'b1;
                    end
                end
                RUN: begin
                    if (is_zero_s) begin
                        state_r      <= DONE;
                        status_r     <= ST_ZERO;
                        steps_r      <= {CNT_W{1'b0}};
                        busy_r       <= 1'b0;
                        done_valid_r <= 1'b1;
                    end else if (is_one_s) begin
                        state_r      <= DONE;
                        status_r     <= ST_OK;
                        busy_r       <= 1'b0;
                        done_valid_r <= 1'b1;
                    end else if (limit_s) begin
                        // Limit is checked before incrementing so the counter never wraps.
                        state_r      <= DONE;
                        status_r     <= ST_LIMIT;
                        busy_r       <= 1'b0;
                        done_valid_r <= 1'b1;
                    end else if (ovf_s) begin
                        // Value and count are left at the last representable point.
                        state_r      <= DONE;
                        status_r     <= ST_OVF;
                        busy_r       <= 1'b0;
                        done_valid_r <= 1'b1;
                    end else begin
                        cur_r   <= next_s;
                        steps_r <= steps_r + STEP_ONE;
                    end
                end
                DONE: begin
                    if (bus.done_ready) begin
                        state_r       <= IDLE;
                        done_valid_r  <= 1'b0;
                        start_ready_r <= 1'b1;
                    end else begin
                        done_valid_r  <= 1'b1;
                    end
                end
                default: begin
                    state_r       <= IDLE;
                    busy_r        <= 1'b0;
                    done_valid_r  <= 1'b0;
                    start_ready_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.start_ready = start_ready_r;
    assign bus.cur_value   = cur_r;
    assign bus.busy        = busy_r;
    assign bus.done_valid  = done_valid_r;
    assign bus.steps       = steps_r;
    assign bus.status      = status_r;

`ifdef COLLATZ_PEAK_EN
    logic [WIDTH-1:0] peak_r;

    // Running maximum of the trajectory, seeded with the start value.
    always_ff @(posedge clk or negedge rst_int_n_s) begin
        if (!rst_int_n_s) begin
            peak_r <= {WIDTH{1'b0}};
        end else if (accept_s) begin
            peak_r <= bus.start_value;
        end else if (advance_s && (next_s > peak_r)) begin
            peak_r <= next_s;
        end else begin
            peak_r <= peak_r;
        end
    end

    assign bus.peak = peak_r;
`endif

endmodule

// File: tb/tb_collatz_seq_engine.sv
// Scoreboard bench for collatz_seq_engine: a driver pushes expected results,
// a monitor pops and compares them whenever a result is presented.
module tb_collatz_seq_engine;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    // Cycle counter used for latency measurement.
    always @(posedge clk) cyc <= cyc + 1;

    collatz_seq_engine_if #(.WIDTH(16), .CNT_W(8)) ifc();
    collatz_seq_engine_if #(.WIDTH(16), .CNT_W(4)) if4();

    collatz_seq_engine #(.WIDTH(16), .CNT_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc)
    );

    collatz_seq_engine #(.WIDTH(16), .CNT_W(4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if4)
    );

    typedef struct {
        int unsigned start;
        int          steps;
        int          status;
        int unsigned cur;
        int unsigned peak;
        int          hs_cyc;
    } exp_t;

    exp_t sb_q[$];
    exp_t cur_e;
    int   hold_cfg = 0;
    bit   in_res = 1'b0;
    bit   have_exp = 1'b0;
    bit   after_hs = 1'b0;
    int   dv_cnt = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: walk the trajectory with plain integer arithmetic.
    task automatic ref_model(input int unsigned n0, input int cnt_w,
                             output int st, output int code,
                             output int unsigned fin, output int unsigned pk);
        longint unsigned n;
        n    = n0;
        st   = 0;
        pk   = n0;
        code = 0;
        if (n == 0) begin
            code = 1;
        end else begin
            while (1) begin
                if (n == 1) begin
                    code = 0;
                    break;
                end
                if (st == (1 << cnt_w) - 1) begin
                    code = 3;
                    break;
                end
                if ((n % 2 == 1) && (3 * n + 1 > 65535)) begin
                    code = 2;
                    break;
                end
                if (n % 2 == 0) n = n / 2;
                else            n = 3 * n + 1;
                st++;
                if (n > pk) pk = n[31:0];
            end
        end
        fin = n[31:0];
    endtask

    task automatic issue(input int unsigned v, input int hold,
                         input int e_steps, input int e_status,
                         input int unsigned e_cur, input int unsigned e_peak);
        exp_t e;
        int   t;
        @(negedge clk);
        ifc.start_value = v[15:0];
        ifc.start_valid = 1'b1;
        t = 0;
        while (!ifc.start_ready && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (!ifc.start_ready) begin
            checks++;
            errors++;
            $display("FAIL start_timeout: start_ready still %0d after %0d cycles, expected 1", ifc.start_ready, t);
            ifc.start_valid = 1'b0;
        end else begin
            hold_cfg = hold;
            e.start  = v;
            e.steps  = e_steps;
            e.status = e_status;
            e.cur    = e_cur;
            e.peak   = e_peak;
            e.hs_cyc = cyc;
            sb_q.push_back(e);
            @(posedge clk);
            #1;
            ifc.start_valid = 1'b0;
        end
    endtask

    task automatic issue_rand(input int unsigned v, input int hold);
        int st, code;
        int unsigned fin, pk;
        ref_model(v, 8, st, code, fin, pk);
        issue(v, hold, st, code, fin, pk);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((sb_q.size() != 0 || in_res) && t < 5000) begin
            @(negedge clk);
            t++;
        end
        chk("drain_timeout", (sb_q.size() != 0 || in_res) ? 1 : 0, 0);
    endtask

    // Monitor and consumer: compare every presented result, apply backpressure.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                ifc.done_ready = 1'b0;
                in_res   = 1'b0;
                after_hs = 1'b0;
                dv_cnt   = 0;
            end else if (ifc.done_valid) begin
                if (!in_res) begin
                    in_res = 1'b1;
                    dv_cnt = 0;
                    if (sb_q.size() == 0) begin
                        have_exp = 1'b0;
                        checks++;
                        errors++;
                        $display("FAIL unexpected_result: got steps=%0d status=%0d cur=%0d, expected no result",
                                 ifc.steps, ifc.status, ifc.cur_value);
                    end else begin
                        have_exp = 1'b1;
                        cur_e = sb_q.pop_front();
                        chk("latency", cyc - cur_e.hs_cyc, cur_e.steps + 2);
                    end
                end
                if (have_exp) begin
                    chk("steps", ifc.steps, cur_e.steps);
                    chk("status", ifc.status, cur_e.status);
                    chk("cur_value", ifc.cur_value, cur_e.cur);
                    chk("busy_in_done", ifc.busy, 0);
                    chk("start_ready_in_done", ifc.start_ready, 0);
`ifdef COLLATZ_PEAK_EN
                    chk("peak", ifc.peak, cur_e.peak);
`endif
                end
                dv_cnt++;
                ifc.done_ready = (dv_cnt > hold_cfg);
                if (ifc.done_ready) begin
                    in_res   = 1'b0;
                    after_hs = 1'b1;
                end
            end else begin
                ifc.done_ready = 1'b0;
                if (after_hs) begin
                    chk("start_ready_after_done", ifc.start_ready, 1);
                    after_hs = 1'b0;
                end
            end
        end
    end

    // Absolute time bound so the run can never hang.
    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog expired");
    end

    // Stimulus sequence.
    initial begin
        int t;
        int hs;
        rst_n           = 1'b0;
        ifc.start_valid = 1'b0;
        ifc.start_value = 16'd0;
        if4.start_valid = 1'b0;
        if4.start_value = 16'd0;
        if4.done_ready  = 1'b0;
        repeat (3) @(negedge clk);

        chk("reset_cur_value", ifc.cur_value, 0);
        chk("reset_steps", ifc.steps, 0);
        chk("reset_status", ifc.status, 0);
        chk("reset_busy", ifc.busy, 0);
        chk("reset_done_valid", ifc.done_valid, 0);
        rst_n = 1'b1;

        // Directed values with hand-derived expectations.
        issue(6, 0, 8, 0, 1, 16);
        drain();
        issue(27, 0, 111, 0, 1, 9232);
        drain();
        issue(0, 1, 0, 1, 0, 0);
        issue(43691, 0, 0, 2, 43691, 43691);
        issue(21845, 2, 0, 2, 21845, 21845);
        issue(1, 0, 0, 0, 1, 1);
        drain();

        // Backpressure plus a start pulse during RUN that must be ignored.
        issue(6, 5, 8, 0, 1, 16);
        repeat (3) @(negedge clk);
        chk("busy_in_run", ifc.busy, 1);
        ifc.start_value = 16'd99;
        ifc.start_valid = 1'b1;
        @(negedge clk);
        ifc.start_valid = 1'b0;
        drain();

        // Reset in the middle of a run: no result, everything back to zero.
        @(negedge clk);
        ifc.start_value = 16'd27;
        ifc.start_valid = 1'b1;
        t = 0;
        while (!ifc.start_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("reset_test_accept", ifc.start_ready, 1);
        @(posedge clk);
        #1;
        ifc.start_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_cur_value", ifc.cur_value, 0);
        chk("abort_steps", ifc.steps, 0);
        chk("abort_status", ifc.status, 0);
        chk("abort_busy", ifc.busy, 0);
        chk("abort_done_valid", ifc.done_valid, 0);
        chk("abort_start_ready", ifc.start_ready, 0);
`ifdef COLLATZ_PEAK_EN
        chk("abort_peak", ifc.peak, 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        issue(6, 0, 8, 0, 1, 16);
        drain();

        // Randomised starts checked against the reference model.
        for (int i = 0; i < 24; i++) begin
            int unsigned v;
            if (i % 2 == 0) v = $urandom_range(1, 300);
            else            v = $urandom_range(0, 65535);
            issue_rand(v, $urandom_range(0, 3));
        end
        issue_rand(21843, 0);
        issue_rand(2, 1);
        drain();

        // Step limit on the narrow-counter instance.
        @(negedge clk);
        if4.start_value = 16'd27;
        if4.start_valid = 1'b1;
        t = 0;
        while (!if4.start_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("lim_accept", if4.start_ready, 1);
        hs = cyc;
        @(posedge clk);
        #1;
        if4.start_valid = 1'b0;
        t = 0;
        @(negedge clk);
        while (!if4.done_valid && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("lim_done_valid", if4.done_valid, 1);
        chk("lim_latency", cyc - hs, 17);
        chk("lim_status", if4.status, 3);
        chk("lim_steps", if4.steps, 15);
        chk("lim_cur_value", if4.cur_value, 242);
        chk("lim_busy", if4.busy, 0);
        if4.done_ready = 1'b1;
        @(negedge clk);
        if4.done_ready = 1'b0;
        chk("lim_done_cleared", if4.done_valid, 0);
        chk("lim_start_ready", if4.start_ready, 1);

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
